// File: rtl/puf_cmd_pkg.sv
// Shared constants and parser state encoding for the PUF host command path.
package puf_cmd_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] OP_EVAL   = 8'h01;
    localparam logic [7:0] OP_STATUS = 8'h02;

    typedef enum logic [2:0] {
        P_SYNC = 3'd0,
        P_OP   = 3'd1,
        P_PAY  = 3'd2,
        P_CSUM = 3'd3,
        P_HOLD = 3'd4
    } pstate_e;

endpackage

// File: rtl/rx_byte_strobe.sv
// Turns the UART receiver's ready level into a one-cycle byte strobe.
// The edge flop resets high so the receiver's own post-reset rise is not seen as a byte.
module rx_byte_strobe (
    input  logic sys_clk,
    input  logic sys_rst_l,
    input  logic rdy_i,
    output logic stb_o
);

    logic rdy_q;
    logic rdy_d;

    always_comb begin
        rdy_d = rdy_i;
        stb_o = rdy_i & ~rdy_q;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) rdy_q <= 1'b1;
        else            rdy_q <= rdy_d;
    end

endmodule

// File: rtl/puf_cmd_parser.sv
// Frame parser: SYNC, opcode, payload, XOR checksum -> validated command held on a valid/ready handshake.
//   state  | meaning
//   P_SYNC | idle, hunting for the sync byte
//   P_OP   | waiting for the opcode byte
//   P_PAY  | collecting challenge bytes into the shadow register
//   P_CSUM | waiting for the checksum byte
//   P_HOLD | command presented, waiting for cmd_readyH
module puf_cmd_parser
    import puf_cmd_pkg::*;
#(
    parameter int CHAL_BYTES     = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_l,
    input  logic [7:0]              rec_dataH,
    input  logic                    rec_readyH,
    output logic                    cmd_validH,
    input  logic                    cmd_readyH,
    output logic [7:0]              cmd_opH,
    output logic [8*CHAL_BYTES-1:0] challengeH,
    output logic                    frame_errH,
    output logic                    overrunH,
    output logic                    busyH
);

    localparam int IDX_W = (CHAL_BYTES > 1) ? $clog2(CHAL_BYTES) : 1;
    localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CHAL_BYTES - 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);

    logic byte_stb;

    pstate_e                 state_q, state_d;
    logic [7:0]              csum_q, csum_d;
    logic [7:0]              op_q, op_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [TMO_W-1:0]        tmo_q, tmo_d;
    logic [8*CHAL_BYTES-1:0] shadow_q, shadow_d;
    logic [8*CHAL_BYTES-1:0] chal_q, chal_d;
    logic [7:0]              cmd_op_q, cmd_op_d;
    logic                    valid_q, valid_d;
    logic                    ferr_q, ferr_d;
    logic                    ovr_q, ovr_d;
    logic                    tmo_active;
    logic                    tmo_hit;

    rx_byte_strobe u_stb (
        .sys_clk   (sys_clk),
        .sys_rst_l (sys_rst_l),
        .rdy_i     (rec_readyH),
        .stb_o     (byte_stb)
    );

    always_comb begin
        state_d  = state_q;
        csum_d   = csum_q;
        op_d     = op_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        chal_d   = chal_q;
        cmd_op_d = cmd_op_q;
        valid_d  = valid_q;
        ferr_d   = 1'b0;
        ovr_d    = 1'b0;

        // Down-counter reloads on every strobe and whenever idle, so state entry always starts it full.
        tmo_active = (state_q == P_OP) || (state_q == P_PAY) || (state_q == P_CSUM);
        tmo_hit    = tmo_active && !byte_stb && (tmo_q == '0);
        tmo_d      = (tmo_active && !byte_stb) ? tmo_q - TMO_W'(1) : TMO_LOAD;

        case (state_q)
            P_SYNC: begin
                if (byte_stb && rec_dataH == SYNC_BYTE) begin
                    state_d = P_OP;
                    csum_d  = 8'h00;
                end
            end
            P_OP: begin
                if (byte_stb) begin
                    op_d   = rec_dataH;
                    csum_d = rec_dataH;
                    if (rec_dataH == OP_EVAL) begin
                        state_d = P_PAY;
                        idx_d   = '0;
                    end else if (rec_dataH == OP_STATUS) begin
                        state_d = P_CSUM;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = P_SYNC;
                    end
                end
            end
            P_PAY: begin
                if (byte_stb) begin
                    shadow_d[8*int'(idx_q) +: 8] = rec_dataH;
                    csum_d = csum_q ^ rec_dataH;
                    if (idx_q == IDX_LAST) state_d = P_CSUM;
                    else                   idx_d   = idx_q + IDX_W'(1);
                end
            end
            P_CSUM: begin
                if (byte_stb) begin
                    if (rec_dataH == csum_q) begin
                        state_d  = P_HOLD;
                        valid_d  = 1'b1;
                        cmd_op_d = op_q;
                        if (op_q == OP_EVAL) chal_d = shadow_q;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = P_SYNC;
                    end
                end
            end
            P_HOLD: begin
                // Any byte arriving while a command is pending, including the accept cycle, is dropped.
                if (byte_stb) ovr_d = 1'b1;
                if (valid_q && cmd_readyH) begin
                    valid_d = 1'b0;
                    state_d = P_SYNC;
                end
            end
            default: state_d = P_SYNC;
        endcase

        if (tmo_hit) begin
            ferr_d  = 1'b1;
            state_d = P_SYNC;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            state_q  <= P_SYNC;
            csum_q   <= '0;
            op_q     <= '0;
            idx_q    <= '0;
            tmo_q    <= TMO_LOAD;
            shadow_q <= '0;
            chal_q   <= '0;
            cmd_op_q <= '0;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            csum_q   <= csum_d;
            op_q     <= op_d;
            idx_q    <= idx_d;
            tmo_q    <= tmo_d;
            shadow_q <= shadow_d;
            chal_q   <= chal_d;
            cmd_op_q <= cmd_op_d;
            valid_q  <= valid_d;
            ferr_q   <= ferr_d;
            ovr_q    <= ovr_d;
        end
    end

    assign cmd_validH = valid_q;
    assign cmd_opH    = cmd_op_q;
    assign challengeH = chal_q;
    assign frame_errH = ferr_q;
    assign overrunH   = ovr_q;
    assign busyH      = (state_q != P_SYNC);

endmodule
